// File: rtl/adc_dual_reader.sv
// -----------------------------------------------------------------------------
// adc_dual_reader
//   Conversion sequencer and lockstep serial reader for the I/Q ADC pair.
//   A free-running period counter paces conversions. Each conversion:
//   raise mclk, wait for both busy lines to go high and then low (with a
//   timeout), clock DATA_W bits out of both ADCs MSB first, then publish the
//   pair with a one-cycle sample_valid strobe. There is no downstream
//   backpressure.
//
//   Ports
//     SYSCLK, NSYSRESET      system clock, async active-low reset
//     enable                 1 = keep converting, 0 = stop after current sample
//     busy_i, busy_q         ADC busy lines (asynchronous, synchronised here)
//     sdoa_i, sdoa_q         ADC serial data
//     mclk_i, mclk_q         conversion start (identical)
//     scka_i, scka_q         serial clock (identical)
//     sample_i, sample_q     last complete words, raw two's complement
//     sample_valid           1-cycle strobe: sample_i/q updated
//     tmo_err                1-cycle strobe: conversion aborted on busy timeout
//     tmo_count              saturating timeout count, cleared only by reset
// -----------------------------------------------------------------------------
module adc_dual_reader #(
    parameter int DATA_W     = 24,
    parameter int SAMPLE_DIV = 100,
    parameter int MCLK_HI    = 2,
    parameter int SCK_HALF   = 1,
    parameter int BUSY_TMO   = 63
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              enable,
    input  logic              busy_i,
    input  logic              busy_q,
    input  logic              sdoa_i,
    input  logic              sdoa_q,
    output logic              mclk_i,
    output logic              mclk_q,
    output logic              scka_i,
    output logic              scka_q,
    output logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] sample_q,
    output logic              sample_valid,
    output logic              tmo_err,
    output logic [7:0]        tmo_count
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [7:0]    MCLK_LAST   = 8'(MCLK_HI - 1);
    localparam logic [7:0]    TMO_LAST    = 8'(BUSY_TMO - 1);
    localparam logic [HW-1:0] HALF_LAST   = HW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BITS_ALL    = BW'(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MCLK    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_n;
    logic [PW-1:0]      period_r;
    logic [7:0]         cyc_r;
    logic [HW-1:0]      ph_r;
    logic [BW-1:0]      bit_r;
    logic               scka_r;
    logic               mclk_r;
    logic [DATA_W-1:0]  shift_i_r;
    logic [DATA_W-1:0]  shift_q_r;
    logic [DATA_W-1:0]  sample_i_r;
    logic [DATA_W-1:0]  sample_q_r;
    logic               valid_r;
    logic               tmo_err_r;
    logic [7:0]         tmo_cnt_r;
    logic               busy_i_meta_r;
    logic               busy_i_sync_r;
    logic               busy_q_meta_r;
    logic               busy_q_sync_r;
    logic               fire_tmo_s;
    logic               half_done_s;

    assign half_done_s = (ph_r == HALF_LAST);

    // Two-flop synchronisers for the asynchronous busy lines.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            busy_i_meta_r <= 1'b0;
            busy_i_sync_r <= 1'b0;
            busy_q_meta_r <= 1'b0;
            busy_q_sync_r <= 1'b0;
        end else begin
            busy_i_meta_r <= busy_i;
            busy_i_sync_r <= busy_i_meta_r;
            busy_q_meta_r <= busy_q;
            busy_q_sync_r <= busy_q_meta_r;
        end
    end

    // Sample-rate period counter; parked at 0 while disabled so re-enable starts at once.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            period_r <= {PW{1'b0}};
        end else if (!enable) begin
            period_r <= {PW{1'b0}};
        end else if (period_r == PERIOD_LAST) begin
            period_r <= {PW{1'b0}};
        end else begin
            period_r <= period_r + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state; a wrap seen outside IDLE is simply lost (no catch-up).
    always_comb begin
        state_n    = state_r;
        fire_tmo_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && (period_r == {PW{1'b0}})) begin
                    state_n = ST_MCLK;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MCLK: begin
                if (cyc_r == MCLK_LAST) begin
                    state_n = ST_WAIT_HI;
                end else begin
                    state_n = ST_MCLK;
                end
            end
            ST_WAIT_HI: begin
                if (busy_i_sync_r || busy_q_sync_r) begin
                    state_n = ST_WAIT_LO;
                end else if (cyc_r == TMO_LAST) begin
                    state_n    = ST_IDLE;
                    fire_tmo_s = 1'b1;
                end else begin
                    state_n = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (!busy_i_sync_r && !busy_q_sync_r) begin
                    state_n = ST_SHIFT;
                end else if (cyc_r == TMO_LAST) begin
                    state_n    = ST_IDLE;
                    fire_tmo_s = 1'b1;
                end else begin
                    state_n = ST_WAIT_LO;
                end
            end
            ST_SHIFT: begin
                // Leave after the high phase of the final scka pulse.
                if (scka_r && half_done_s && (bit_r == BITS_ALL)) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Cycle counter from the mclk rise; times both the mclk pulse and the busy timeout.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            cyc_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && (state_n == ST_MCLK)) begin
            cyc_r <= 8'd0;
        end else if (cyc_r != 8'hFF) begin
            cyc_r <= cyc_r + 8'd1;
        end else begin
            cyc_r <= cyc_r;
        end
    end

    // scka generation and MSB-first capture on the last clk of each low phase.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            scka_r    <= 1'b0;
            ph_r      <= {HW{1'b0}};
            bit_r     <= {BW{1'b0}};
            shift_i_r <= {DATA_W{1'b0}};
            shift_q_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            if (half_done_s) begin
                ph_r <= {HW{1'b0}};
                if (!scka_r) begin
                    scka_r    <= 1'b1;
                    bit_r     <= bit_r + 1'b1;
                    shift_i_r <= {shift_i_r[DATA_W-2:0], sdoa_i};
                    shift_q_r <= {shift_q_r[DATA_W-2:0], sdoa_q};
                end else begin
                    scka_r <= 1'b0;
                end
            end else begin
                ph_r <= ph_r + 1'b1;
            end
        end else begin
            scka_r <= 1'b0;
            ph_r   <= {HW{1'b0}};
            bit_r  <= {BW{1'b0}};
        end
    end

    // Registered outputs: mclk, sample publish, timeout strobe and counter.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            mclk_r     <= 1'b0;
            valid_r    <= 1'b0;
            sample_i_r <= {DATA_W{1'b0}};
            sample_q_r <= {DATA_W{1'b0}};
            tmo_err_r  <= 1'b0;
            tmo_cnt_r  <= 8'd0;
        end else begin
            mclk_r    <= (state_n == ST_MCLK);
            valid_r   <= (state_n == ST_DONE);
            tmo_err_r <= fire_tmo_s;
            if (state_n == ST_DONE) begin
                sample_i_r <= shift_i_r;
                sample_q_r <= shift_q_r;
            end else begin
                sample_i_r <= sample_i_r;
                sample_q_r <= sample_q_r;
            end
            if (fire_tmo_s && (tmo_cnt_r != 8'hFF)) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

    assign mclk_i       = mclk_r;
    assign mclk_q       = mclk_r;
    assign scka_i       = scka_r;
    assign scka_q       = scka_r;
    assign sample_i     = sample_i_r;
    assign sample_q     = sample_q_r;
    assign sample_valid = valid_r;
    assign tmo_err      = tmo_err_r;
    assign tmo_count    = tmo_cnt_r;

endmodule

// File: tb/tb_adc_dual_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_dual_reader
//   Bench for adc_dual_reader. Instance 0 uses the default parameters and a
//   behavioural ADC pair (busy pulse ~600 ns after mclk fall, serial word
//   presented MSB first and advanced on each scka rise). Instance 1 runs with
//   SAMPLE_DIV=50 against fixed words.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_dual_reader;
    localparam int DW = 24;

    logic SYSCLK = 1'b0;
    logic NSYSRESET = 1'b0;
    always #20 SYSCLK = ~SYSCLK;

    int n_pass = 0;
    int n_total = 0;

    // Instance 0 (default parameters)
    logic en0 = 1'b0;
    logic busy_i0, busy_q0;
    logic sdoa_i0 = 1'b0, sdoa_q0 = 1'b0;
    logic mclk_i0, mclk_q0, scka_i0, scka_q0, sample_valid0, tmo_err0;
    logic [DW-1:0] sample_i0, sample_q0;
    logic [7:0] tmo_count0;

    // Instance 1 (SAMPLE_DIV = 50)
    logic en1 = 1'b0;
    logic busy_i1, busy_q1;
    logic sdoa_i1 = 1'b0, sdoa_q1 = 1'b0;
    logic mclk_i1, mclk_q1, scka_i1, scka_q1, sample_valid1, tmo_err1;
    logic [DW-1:0] sample_i1, sample_q1;
    logic [7:0] tmo_count1;

    adc_dual_reader dut (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .enable(en0),
        .busy_i(busy_i0), .busy_q(busy_q0), .sdoa_i(sdoa_i0), .sdoa_q(sdoa_q0),
        .mclk_i(mclk_i0), .mclk_q(mclk_q0), .scka_i(scka_i0), .scka_q(scka_q0),
        .sample_i(sample_i0), .sample_q(sample_q0), .sample_valid(sample_valid0),
        .tmo_err(tmo_err0), .tmo_count(tmo_count0)
    );

    adc_dual_reader #(.SAMPLE_DIV(50)) dut50 (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .enable(en1),
        .busy_i(busy_i1), .busy_q(busy_q1), .sdoa_i(sdoa_i1), .sdoa_q(sdoa_q1),
        .mclk_i(mclk_i1), .mclk_q(mclk_q1), .scka_i(scka_i1), .scka_q(scka_q1),
        .sample_i(sample_i1), .sample_q(sample_q1), .sample_valid(sample_valid1),
        .tmo_err(tmo_err1), .tmo_count(tmo_count1)
    );

    // ---------------- ADC model, instance 0 ----------------
    logic rnd0 = 1'b0;
    logic hold_q0 = 1'b0;
    logic [DW-1:0] cur_i0 = '0, cur_q0 = '0, exp_i0 = '0, exp_q0 = '0;
    int rises0 = 0;

    // New word at mclk rise; advance one bit per scka rise; the word counts as
    // delivered once all DW bits have been clocked out.
    always @(posedge mclk_i0 or posedge scka_i0) begin
        if (scka_i0) begin
            rises0 = rises0 + 1;
            if (rises0 == DW) begin
                exp_i0 = cur_i0;
                exp_q0 = cur_q0;
            end
            if (rises0 < DW) begin
                sdoa_i0 = cur_i0[DW-1-rises0];
                sdoa_q0 = cur_q0[DW-1-rises0];
            end
        end else begin
            cur_i0 = rnd0 ? DW'($urandom) : 24'hA5A5A5;
            cur_q0 = rnd0 ? DW'($urandom) : 24'h5A5A5A;
            rises0 = 0;
            sdoa_i0 = cur_i0[DW-1];
            sdoa_q0 = cur_q0[DW-1];
        end
    end

    initial begin
        busy_i0 = 1'b0;
        busy_q0 = 1'b0;
        forever begin
            @(posedge mclk_i0);
            #30;
            busy_i0 = 1'b1;
            busy_q0 = 1'b1;
            @(negedge mclk_i0);
            #615;
            busy_i0 = 1'b0;
            busy_q0 = hold_q0;
        end
    end

    time mlast0 = 0, mper0 = 0;
    int mrise0 = 0;
    logic pair_bad0 = 1'b0;
    always @(posedge mclk_i0) begin
        if (mlast0 != 0) mper0 = $time - mlast0;
        mlast0 = $time;
        mrise0 = mrise0 + 1;
    end
    always @(posedge SYSCLK) begin
        if ((mclk_i0 !== mclk_q0) || (scka_i0 !== scka_q0)) pair_bad0 = 1'b1;
    end

    // ---------------- ADC model, instance 1 ----------------
    logic [DW-1:0] cur_i1 = 24'h123456, cur_q1 = 24'hFEDCBA;
    int rises1 = 0;
    always @(posedge mclk_i1 or posedge scka_i1) begin
        if (scka_i1) begin
            rises1 = rises1 + 1;
            if (rises1 < DW) begin
                sdoa_i1 = cur_i1[DW-1-rises1];
                sdoa_q1 = cur_q1[DW-1-rises1];
            end
        end else begin
            rises1 = 0;
            sdoa_i1 = cur_i1[DW-1];
            sdoa_q1 = cur_q1[DW-1];
        end
    end

    initial begin
        busy_i1 = 1'b0;
        busy_q1 = 1'b0;
        forever begin
            @(posedge mclk_i1);
            #30;
            busy_i1 = 1'b1;
            busy_q1 = 1'b1;
            @(negedge mclk_i1);
            #615;
            busy_i1 = 1'b0;
            busy_q1 = 1'b0;
        end
    end

    time mlast1 = 0, mper1 = 0;
    logic ovl1 = 1'b0;
    always @(posedge mclk_i1) begin
        if (mlast1 != 0) mper1 = $time - mlast1;
        mlast1 = $time;
    end
    always @(posedge SYSCLK) begin
        if (mclk_i1 && scka_i1) ovl1 = 1'b1;
    end

    // Wait (bounded) for a valid strobe on instance 0; cycles counted from call.
    task automatic wait_valid0(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < budget) begin
            @(negedge SYSCLK);
            cyc++;
            if (sample_valid0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait (bounded) for scka high on instance 0, i.e. mid readout.
    task automatic wait_shift0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge SYSCLK);
            if (scka_i0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        NSYSRESET = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (3) @(negedge SYSCLK);
        n_total++;
        if ({mclk_i0, mclk_q0, scka_i0, scka_q0, sample_valid0, tmo_err0} !== 6'b0)
            $display("FAIL reset_strobes0: got %b expected 000000",
                     {mclk_i0, mclk_q0, scka_i0, scka_q0, sample_valid0, tmo_err0});
        else n_pass++;
        n_total++;
        if ({sample_i0, sample_q0} !== 48'h0)
            $display("FAIL reset_samples0: got %h expected 0", {sample_i0, sample_q0});
        else n_pass++;
        n_total++;
        if (tmo_count0 !== 8'd0) $display("FAIL reset_tmo_count0: got %0d expected 0", tmo_count0);
        else n_pass++;
        n_total++;
        if ({mclk_i1, scka_i1, sample_valid1, tmo_err1, sample_i1} !== 28'h0)
            $display("FAIL reset_outputs1: got %h expected 0", {mclk_i1, scka_i1, sample_valid1, tmo_err1, sample_i1});
        else n_pass++;
        NSYSRESET = 1'b1;
    endtask

    task automatic test_fixed();
        int cyc;
        bit ok;
        rnd0 = 1'b0;
        en0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid0(150, cyc, ok);
            n_total++;
            if (!ok) $display("FAIL fixed_valid_timeout[%0d]: got no valid expected one within 150", k);
            else n_pass++;
            n_total++;
            if (sample_i0 !== 24'hA5A5A5) $display("FAIL fixed_i[%0d]: got %h expected a5a5a5", k, sample_i0);
            else n_pass++;
            n_total++;
            if (sample_q0 !== 24'h5A5A5A) $display("FAIL fixed_q[%0d]: got %h expected 5a5a5a", k, sample_q0);
            else n_pass++;
            if (k > 0) begin
                n_total++;
                if (cyc !== 100) $display("FAIL fixed_interval[%0d]: got %0d expected 100", k, cyc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit ok;
        rnd0 = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wait_valid0(150, cyc, ok);
            n_total++;
            if (!ok) $display("FAIL rnd_valid_timeout[%0d]: got no valid expected one within 150", k);
            else n_pass++;
            n_total++;
            if ({sample_i0, sample_q0} !== {exp_i0, exp_q0})
                $display("FAIL rnd_word[%0d]: got %h/%h expected %h/%h", k, sample_i0, sample_q0, exp_i0, exp_q0);
            else n_pass++;
            n_total++;
            if (rises0 !== DW) $display("FAIL rnd_scka_rises[%0d]: got %0d expected %0d", k, rises0, DW);
            else n_pass++;
            n_total++;
            if (cyc !== 100) $display("FAIL rnd_interval[%0d]: got %0d expected 100", k, cyc);
            else n_pass++;
            n_total++;
            if (mper0 !== 64'd4000) $display("FAIL rnd_mclk_period[%0d]: got %0d expected 4000", k, mper0);
            else n_pass++;
        end
        n_total++;
        if (pair_bad0 !== 1'b0) $display("FAIL iq_pair_equal: got %b expected 0", pair_bad0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        int vcnt;
        int cyc;
        bit ok;
        logic [DW-1:0] held_i;
        held_i = exp_i0;
        hold_q0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge SYSCLK);
            if (mclk_i0) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (!ok) $display("FAIL tmo_mclk_timeout: got no mclk expected one within 150");
        else n_pass++;
        n = 0;
        vcnt = 0;
        while (n < 100 && !tmo_err0) begin
            @(negedge SYSCLK);
            n++;
            if (sample_valid0) vcnt++;
        end
        n_total++;
        if (n !== 63) $display("FAIL tmo_latency: got %0d expected 63", n);
        else n_pass++;
        n_total++;
        if (tmo_count0 !== 8'd1) $display("FAIL tmo_count: got %0d expected 1", tmo_count0);
        else n_pass++;
        n_total++;
        if (vcnt !== 0) $display("FAIL tmo_no_valid: got %0d expected 0", vcnt);
        else n_pass++;
        n_total++;
        if (sample_i0 !== held_i) $display("FAIL tmo_sample_hold: got %h expected %h", sample_i0, held_i);
        else n_pass++;
        @(negedge SYSCLK);
        n_total++;
        if (tmo_err0 !== 1'b0) $display("FAIL tmo_pulse_width: got %b expected 0", tmo_err0);
        else n_pass++;
        hold_q0 = 1'b0;
        wait_valid0(200, cyc, ok);
        n_total++;
        if (!ok) $display("FAIL tmo_recover_timeout: got no valid expected one within 200");
        else n_pass++;
        n_total++;
        if ({sample_i0, sample_q0} !== {exp_i0, exp_q0})
            $display("FAIL tmo_recover_word: got %h/%h expected %h/%h", sample_i0, sample_q0, exp_i0, exp_q0);
        else n_pass++;
        n_total++;
        if (tmo_count0 !== 8'd1) $display("FAIL tmo_count_after: got %0d expected 1", tmo_count0);
        else n_pass++;
    endtask

    task automatic test_enable();
        int cyc;
        int m0;
        bit ok;
        wait_shift0(ok);
        n_total++;
        if (!ok) $display("FAIL en_shift_timeout: got no scka expected one within 200");
        else n_pass++;
        en0 = 1'b0;
        wait_valid0(100, cyc, ok);
        n_total++;
        if (!ok) $display("FAIL en_drain_timeout: got no valid expected one within 100");
        else n_pass++;
        n_total++;
        if ({sample_i0, sample_q0} !== {exp_i0, exp_q0})
            $display("FAIL en_drain_word: got %h/%h expected %h/%h", sample_i0, sample_q0, exp_i0, exp_q0);
        else n_pass++;
        m0 = mrise0;
        repeat (300) @(negedge SYSCLK);
        n_total++;
        if (mrise0 !== m0) $display("FAIL en_no_mclk: got %0d rises expected 0", mrise0 - m0);
        else n_pass++;
        en0 = 1'b1;
        @(negedge SYSCLK);
        n_total++;
        if (mclk_i0 !== 1'b1) $display("FAIL en_restart_mclk: got %b expected 1", mclk_i0);
        else n_pass++;
        wait_valid0(150, cyc, ok);
        n_total++;
        if ({sample_i0, sample_q0} !== {exp_i0, exp_q0})
            $display("FAIL en_restart_word: got %h/%h expected %h/%h", sample_i0, sample_q0, exp_i0, exp_q0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        wait_shift0(ok);
        n_total++;
        if (!ok) $display("FAIL rstmid_shift_timeout: got no scka expected one within 200");
        else n_pass++;
        #5;
        NSYSRESET = 1'b0;
        #1;
        n_total++;
        if ({scka_i0, scka_q0, sample_valid0, mclk_i0} !== 4'b0)
            $display("FAIL rstmid_strobes: got %b expected 0000", {scka_i0, scka_q0, sample_valid0, mclk_i0});
        else n_pass++;
        n_total++;
        if ({sample_i0, sample_q0} !== 48'h0)
            $display("FAIL rstmid_samples: got %h expected 0", {sample_i0, sample_q0});
        else n_pass++;
        n_total++;
        if (tmo_count0 !== 8'd0) $display("FAIL rstmid_tmo_count: got %0d expected 0", tmo_count0);
        else n_pass++;
        repeat (3) @(negedge SYSCLK);
        NSYSRESET = 1'b1;
        wait_valid0(150, cyc, ok);
        n_total++;
        if (!ok) $display("FAIL rstmid_valid_timeout: got no valid expected one within 150");
        else n_pass++;
        n_total++;
        if ({sample_i0, sample_q0} !== {cur_i0, cur_q0})
            $display("FAIL rstmid_full_word: got %h/%h expected %h/%h", sample_i0, sample_q0, cur_i0, cur_q0);
        else n_pass++;
        n_total++;
        if (rises0 !== DW) $display("FAIL rstmid_rises: got %0d expected %0d", rises0, DW);
        else n_pass++;
    endtask

    task automatic test_short_div();
        int cyc;
        bit ok;
        en1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            ok = 1'b0;
            while (cyc < 150) begin
                @(negedge SYSCLK);
                cyc++;
                if (sample_valid1) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_total++;
            if (!ok) $display("FAIL div50_valid_timeout[%0d]: got no valid expected one within 150", k);
            else n_pass++;
            n_total++;
            if ({sample_i1, sample_q1} !== 48'h123456FEDCBA)
                $display("FAIL div50_word[%0d]: got %h/%h expected 123456/fedcba", k, sample_i1, sample_q1);
            else n_pass++;
            n_total++;
            if (rises1 !== DW) $display("FAIL div50_rises[%0d]: got %0d expected %0d", k, rises1, DW);
            else n_pass++;
            if (k > 0) begin
                n_total++;
                if (cyc !== 100) $display("FAIL div50_interval[%0d]: got %0d expected 100", k, cyc);
                else n_pass++;
                n_total++;
                if (mper1 !== 64'd4000) $display("FAIL div50_mclk_period[%0d]: got %0d expected 4000", k, mper1);
                else n_pass++;
            end
        end
        n_total++;
        if (ovl1 !== 1'b0) $display("FAIL div50_overlap: got %b expected 0", ovl1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_short_div();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
